// File: rtl/pipe_muldiv_ctrl.sv
// Iterative multiply/divide sequencer for the EXE stage: shift-add multiply and
// restoring divide, one bit per cycle, with pipeline stall and HI/LO write-back.
module pipe_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             hi_wena_o,
    output logic             lo_wena_o
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   addend_reg, addend_next;
    logic               is_div_reg, is_div_next;
    logic               neg_res_reg, neg_res_next;
    logic               neg_rem_reg, neg_rem_next;
    logic [WIDTH-1:0]   hi_reg, hi_next, lo_reg, lo_next;

    logic             accept, is_signed_in, is_div_in, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, rem_shift, div_diff;
    logic [WIDTH-1:0] mul_add;
    logic [2*WIDTH-1:0] prod_fixed;

    assign is_div_in    = op_i[1];
    assign is_signed_in = ~op_i[0];
    assign a_neg        = is_signed_in & a_i[WIDTH-1];
    assign b_neg        = is_signed_in & b_i[WIDTH-1];
    assign mag_a        = a_neg ? -a_i : a_i;
    assign mag_b        = b_neg ? -b_i : b_i;
    assign accept       = start_i & ~flush_i & ((state_reg == IDLE) || (state_reg == DONE));

    // Multiply: the multiplier sits in the low half and is consumed LSB first.
    assign mul_add = acc_reg[0] ? addend_reg : '0;
    assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

    // Divide: remainder in the high half, dividend shifts out of the low half
    // while quotient bits shift in behind it.
    assign rem_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_diff  = rem_shift - {1'b0, addend_reg};

    assign prod_fixed = neg_res_reg ? -acc_reg : acc_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        addend_next  = addend_reg;
        is_div_next  = is_div_reg;
        neg_res_next = neg_res_reg;
        neg_rem_next = neg_rem_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    state_next = IDLE;
                    if (accept) begin
                        if (is_div_in && (b_i == '0)) begin
                            state_next = DONE;
                            hi_next    = a_i;
                            lo_next    = '1;
                        end else begin
                            state_next   = CALC;
                            cnt_next     = '0;
                            acc_next     = {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
                            addend_next  = is_div_in ? mag_b : mag_a;
                            is_div_next  = is_div_in;
                            neg_res_next = a_neg ^ b_neg;
                            neg_rem_next = a_neg;
                        end
                    end
                end
                CALC: begin
                    cnt_next = cnt_reg + CW'(1);
                    if (is_div_reg) begin
                        acc_next = div_diff[WIDTH]
                                 ? {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
                    end
                    if (cnt_reg == LAST_CNT) begin
                        state_next = FIX;
                    end
                end
                FIX: begin
                    state_next = DONE;
                    if (is_div_reg) begin
                        lo_next = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
                        hi_next = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
                    end else begin
                        hi_next = prod_fixed[2*WIDTH-1:WIDTH];
                        lo_next = prod_fixed[WIDTH-1:0];
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            addend_reg  <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            addend_reg  <= addend_next;
            is_div_reg  <= is_div_next;
            neg_res_reg <= neg_res_next;
            neg_rem_reg <= neg_rem_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign busy_o    = (state_reg == CALC) || (state_reg == FIX);
    assign done_o    = (state_reg == DONE);
    assign hi_wena_o = done_o;
    assign lo_wena_o = done_o;
    assign stall_o   = accept | busy_o;
    assign hi_o      = hi_reg;
    assign lo_o      = lo_reg;
endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Bench for pipe_muldiv_ctrl: vector table, flush/reset/back-to-back sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_pipe_muldiv_ctrl;
    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        flush_i;
    logic        stall_o, busy_o, done_o, hi_wena_o, lo_wena_o;
    logic [31:0] hi_o, lo_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_hi = 0, prev_lo = 0;

    pipe_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o), .hi_wena_o(hi_wena_o), .lo_wena_o(lo_wena_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        bit          chain;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit / integer arithmetic on the architectural values.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        int sa, sb, q, r;
        logic [63:0] res;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin sp = longint'(sa) * longint'(sb); res = sp; end
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) res = {32'h0, 32'h80000000};
                else begin q = sa / sb; r = sa % sb; res = {r, q}; end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Called just after a negedge; returns after the done cycle (or, if chained,
    // inside the done cycle so the next op can be accepted from DONE).
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_lat, input bit chain);
        int k;
        int bad_hold;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        #1;
        chk("stall_at_accept", stall_o, 1'b1);
        @(posedge clk);
        #1;
        start_i = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
        k = 0;
        bad_hold = 0;
        @(negedge clk);
        while (!done_o && k < 60) begin
            if (!stall_o || !busy_o || hi_o !== prev_hi || lo_o !== prev_lo) bad_hold++;
            @(negedge clk);
            k++;
        end
        chk("busy_hold", bad_hold, 0);
        chk("latency", k, exp_lat);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h) lat=%0d", op, a, b, hi_o, lo_o, exp_hi, exp_lo, k);
        chk("hi", hi_o, exp_hi);
        chk("lo", lo_o, exp_lo);
        chk("wena", {hi_wena_o, lo_wena_o}, 2'b11);
        chk("stall_busy_in_done", {stall_o, busy_o}, 2'b00);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
        if (!chain) begin
            @(negedge clk);
            chk("done_one_cycle", {done_o, hi_wena_o, lo_wena_o}, 3'b000);
            chk("hold_after_done", {hi_o, lo_o}, {exp_hi, exp_lo});
        end
    endtask

    task automatic rand_op(input bit chain);
        logic [1:0] op;
        logic [31:0] a, b;
        logic [63:0] e;
        op = 2'($urandom);
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        case ($urandom_range(0, 7))
            0:       b = 32'h0;
            1, 2:    b = 32'($urandom_range(1, 20)) ^ ({32{$urandom_range(0, 1) == 1}});
            default: b = $urandom;
        endcase
        e = model(op, a, b);
        do_op(op, a, b, e[63:32], e[31:0], (op[1] && b == 0) ? 0 : 33, chain);
    endtask

    initial begin
        int noise;
        tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 1'b1};
        tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 1'b0};
        tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
        tbl[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1};
        tbl[4] = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 0,  1'b0};
        tbl[5] = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 0,  1'b0};
        tbl[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0};
        tbl[7] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33, 1'b0};
        tbl[8] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0};
        tbl[9] = '{2'b01, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 33, 1'b0};

        rst = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; a_i = 0; b_i = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {hi_o, lo_o, stall_o, busy_o, done_o, hi_wena_o, lo_wena_o}, 69'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].lat, tbl[i].chain);

        // Flush at cnt=10: squashed op, previous result retained.
        start_i = 1'b1; op_i = 2'b01; a_i = 32'h00000003; b_i = 32'h00000005;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_idle", {busy_o, done_o, stall_o}, 3'b000);
        flush_i = 1'b0;
        noise = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o || busy_o || hi_wena_o || lo_wena_o) noise++;
        end
        chk("flush_no_done", noise, 0);
        chk("flush_hold", {hi_o, lo_o}, {prev_hi, prev_lo});
        $display("flush: hi=%h lo=%h", hi_o, lo_o);

        // Flush beats start in the same cycle.
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; a_i = 32'h9; b_i = 32'h9;
        #1 chk("flush_beats_start_stall", stall_o, 1'b0);
        @(negedge clk);
        chk("flush_beats_start_state", {busy_o, done_o}, 2'b00);
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);

        // Reset mid-operation.
        start_i = 1'b1; op_i = 2'b11; a_i = 32'h00FF00FF; b_i = 32'h00000013;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1 chk("midop_reset", {hi_o, lo_o, stall_o, busy_o, done_o, hi_wena_o, lo_wena_o}, 69'h0);
        $display("reset: hi=%h lo=%h busy=%b", hi_o, lo_o, busy_o);
        @(negedge clk);
        rst = 1'b1;
        prev_hi = 0; prev_lo = 0;
        @(negedge clk);
        do_op(tbl[2].op, tbl[2].a, tbl[2].b, tbl[2].hi, tbl[2].lo, tbl[2].lat, 1'b0);

        for (int i = 0; i < 40; i++)
            rand_op((i < 39) && ($urandom_range(0, 3) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
